// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: 2-FF input synchroniser, start-glitch rejection, parity/frame/overrun flags, valid/ready output.
// Optional UART_RX_MAJORITY_EN: every sample is the 2-of-3 majority of rx_s at the nominal count and the two counts before it.
module uart_rx_ext #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 data_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err
);

   localparam int              BW      = $clog2(DATA_BITS + 1);
   localparam logic [15:0]     LP_MID  = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0]     LP_END  = 16'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0]   LP_LAST = BW'(DATA_BITS - 1);
   localparam logic            LP_STOP_LAST = 1'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic [2:0]           r_state;
   logic [15:0]          r_cnt;
   logic [BW-1:0]        r_bit_cnt;
   logic                 r_stop_cnt;
   logic [DATA_BITS-1:0] r_shreg;
   logic                 r_perr_acc;
   logic                 r_ferr_acc;
   logic [DATA_BITS-1:0] r_data_out;
   logic                 r_valid;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 r_ovr;

   logic w_sample;
   logic w_at_mid;
   logic w_at_end;
   logic w_done;
   logic w_accept;
   logic w_par_err;
   logic w_frame_ferr;

`ifdef UART_RX_MAJORITY_EN
   // r_rx_h[0] is rx_s one count earlier, r_rx_h[1] two counts earlier
   logic [1:0] r_rx_h;

   always_ff @(posedge clk) begin
      if (rst) r_rx_h <= 2'b11;
      else     r_rx_h <= {r_rx_h[0], r_rx_s};
   end

   assign w_sample = (r_rx_s & r_rx_h[0]) | (r_rx_s & r_rx_h[1]) | (r_rx_h[0] & r_rx_h[1]);
`else
   assign w_sample = r_rx_s;
`endif

   assign w_at_mid     = (r_cnt == LP_MID);
   assign w_at_end     = (r_cnt == LP_END);
   assign w_done       = (r_state == S_STOP) && w_at_end && (r_stop_cnt == LP_STOP_LAST);
   assign w_accept     = ~r_valid | data_ready;
   assign w_par_err    = (PARITY_MODE == 1) ? ~(^r_shreg ^ w_sample) : (^r_shreg ^ w_sample);
   assign w_frame_ferr = r_ferr_acc | ~w_sample;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta  <= 1'b1;
         r_rx_s     <= 1'b1;
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_shreg    <= '0;
         r_perr_acc <= 1'b0;
         r_ferr_acc <= 1'b0;
         r_data_out <= '0;
         r_valid    <= 1'b0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         r_ovr      <= 1'b0;
      end else begin
         r_rx_meta <= data_in;
         r_rx_s    <= r_rx_meta;

         case (r_state)
            S_IDLE: begin
               if (!r_rx_s) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
               end
            end
            S_START: begin
               if (w_at_mid) begin
                  r_cnt <= '0;
                  if (!w_sample) begin
                     r_state    <= S_DATA;
                     r_bit_cnt  <= '0;
                     r_perr_acc <= 1'b0;
                     r_ferr_acc <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (w_at_end) begin
                  r_cnt     <= '0;
                  r_shreg   <= {w_sample, r_shreg[DATA_BITS-1:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == LP_LAST) begin
                     r_stop_cnt <= 1'b0;
                     r_state    <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_PARITY: begin
               if (w_at_end) begin
                  r_cnt      <= '0;
                  r_perr_acc <= w_par_err;
                  r_stop_cnt <= 1'b0;
                  r_state    <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (w_at_end) begin
                  r_cnt      <= '0;
                  r_ferr_acc <= w_frame_ferr;
                  r_stop_cnt <= r_stop_cnt + 1'b1;
                  // Leave mid stop bit so the next falling edge is caught on time
                  if (r_stop_cnt == LP_STOP_LAST) r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         r_ovr <= 1'b0;
         if (w_done) begin
            if (w_accept) begin
               r_data_out <= r_shreg;
               r_valid    <= 1'b1;
               r_perr     <= r_perr_acc;
               r_ferr     <= w_frame_ferr;
            end else begin
               r_ovr <= 1'b1;
            end
         end else if (r_valid && data_ready) begin
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
         end
      end
   end

   assign data_out    = r_data_out;
   assign data_valid  = r_valid;
   assign parity_err  = r_perr;
   assign frame_err   = r_ferr;
   assign overrun_err = r_ovr;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: three parameter sets driven from one serial line model, table vectors plus random frames.
module tb_uart_rx_ext;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line = 1'b1;
   int         sel = 0;
   logic [2:0] rdy = 3'b000;

   always #5 clk = ~clk;

   logic       din0, din1, din2;
   logic [7:0] d0, d1;
   logic [6:0] d2;
   logic       v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2;

   assign din0 = (sel == 0) ? line : 1'b1;
   assign din1 = (sel == 1) ? line : 1'b1;
   assign din2 = (sel == 2) ? line : 1'b1;

   uart_rx_ext u0 (
      .clk(clk), .rst(rst), .data_in(din0), .data_out(d0), .data_valid(v0),
      .data_ready(rdy[0]), .parity_err(pe0), .frame_err(fe0), .overrun_err(ov0));

   uart_rx_ext #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) u1 (
      .clk(clk), .rst(rst), .data_in(din1), .data_out(d1), .data_valid(v1),
      .data_ready(rdy[1]), .parity_err(pe1), .frame_err(fe1), .overrun_err(ov1));

   uart_rx_ext #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u2 (
      .clk(clk), .rst(rst), .data_in(din2), .data_out(d2), .data_valid(v2),
      .data_ready(rdy[2]), .parity_err(pe2), .frame_err(fe2), .overrun_err(ov2));

   logic [8:0] m_data;
   logic       m_vld, m_perr, m_ferr;

   always_comb begin
      m_data = {1'b0, d0};
      m_vld  = v0;
      m_perr = pe0;
      m_ferr = fe0;
      if (sel == 1) begin
         m_data = {1'b0, d1}; m_vld = v1; m_perr = pe1; m_ferr = fe1;
      end else if (sel == 2) begin
         m_data = {2'b00, d2}; m_vld = v2; m_perr = pe2; m_ferr = fe2;
      end
   end

   int   ovr_hi = 0, ovr_rise = 0;
   logic ovr_prev = 1'b0;
   always @(negedge clk) begin
      if (ov0) ovr_hi++;
      if (ov0 && !ovr_prev) ovr_rise++;
      ovr_prev = ov0;
   end

   int n_tests = 0, n_fail = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int nb_of(input int d);   return (d == 2) ? 7 : 8;  endfunction
   function automatic int clk_of(input int d);  return (d == 2) ? 8 : 16; endfunction
   function automatic int stop_of(input int d); return (d == 1) ? 2 : 1;  endfunction
   function automatic int pm_of(input int d);   return (d == 0) ? 0 : ((d == 1) ? 2 : 1); endfunction

   // Reference rule: odd mode wants an odd count of ones over data+parity, even mode an even count
   function automatic logic exp_perr(input int d, input logic [8:0] data, input int pbit);
      int ones;
      ones = $countones(data) + pbit;
      if (pm_of(d) == 1) return (ones % 2) == 0;
      if (pm_of(d) == 2) return (ones % 2) == 1;
      return 1'b0;
   endfunction

   // Drive one frame; gb/gc invert the line for one cycle at (frame bit, cycle), max_cyc truncates
   task automatic send(input int d, input logic [8:0] data, input int pbit, input logic [1:0] stop_lv,
                       input int gb, input int gc, input int max_cyc);
      logic bits[$];
      int   cyc;
      logic [31:0] pb;
      pb = pbit;
      sel = d;
      bits.push_back(1'b0);
      for (int i = 0; i < nb_of(d); i++) bits.push_back(data[i]);
      if (pm_of(d) != 0) bits.push_back(pb[0]);
      for (int s = 0; s < stop_of(d); s++) bits.push_back(stop_lv[s]);
      cyc = 0;
      for (int b = 0; b < bits.size(); b++) begin
         for (int c = 0; c < clk_of(d); c++) begin
            if (max_cyc >= 0 && cyc >= max_cyc) line = 1'b1;
            else line = bits[b] ^ ((b == gb) && (c == gc));
            cyc++;
            step();
         end
      end
      line = 1'b1;
   endtask

   task automatic wait_valid(input string nm);
      for (int i = 0; i < 400 && !m_vld; i++) step();
      check({nm, "_vld"}, m_vld, 1);
   endtask

   task automatic take(input string nm);
      rdy[sel] = 1'b1;
      step();
      rdy[sel] = 1'b0;
      check({nm, "_clr"}, {m_vld, m_perr, m_ferr}, 0);
   endtask

   typedef struct {
      int         dut;
      logic [8:0] data;
      int         pbit;
      logic [1:0] stop_lv;
      logic [8:0] exp_data;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   vec_t vecs[11];

   localparam logic [8:0] MAJ_EXP =
`ifdef UART_RX_MAJORITY_EN
      9'h055;
`else
      9'h05D;
`endif

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{0, 9'h0A5, -1, 2'b11, 9'h0A5, 1'b0, 1'b0};
      vecs[1]  = '{0, 9'h03C, -1, 2'b11, 9'h03C, 1'b0, 1'b0};
      vecs[2]  = '{1, 9'h007,  0, 2'b11, 9'h007, 1'b1, 1'b0};
      vecs[3]  = '{1, 9'h007,  1, 2'b11, 9'h007, 1'b0, 1'b0};
      vecs[4]  = '{1, 9'h05A,  0, 2'b01, 9'h05A, 1'b0, 1'b1};
      vecs[5]  = '{1, 9'h0C3,  0, 2'b10, 9'h0C3, 1'b0, 1'b1};
      vecs[6]  = '{1, 9'h0FF,  1, 2'b00, 9'h0FF, 1'b1, 1'b1};
      vecs[7]  = '{2, 9'h055,  1, 2'b01, 9'h055, 1'b0, 1'b0};
      vecs[8]  = '{2, 9'h07F,  1, 2'b01, 9'h07F, 1'b1, 1'b0};
      vecs[9]  = '{0, 9'h000, -1, 2'b11, 9'h000, 1'b0, 1'b0};
      vecs[10] = '{0, 9'h0FF, -1, 2'b11, 9'h0FF, 1'b0, 1'b0};

      repeat (3) step();
      rst = 1'b0;
      step();
      check("rst_u0", {d0, v0, pe0, fe0, ov0}, 0);
      check("rst_u1", {d1, v1, pe1, fe1, ov1}, 0);
      check("rst_u2", {d2, v2, pe2, fe2, ov2}, 0);

      // Short low pulse on an idle line must not start a frame
      sel = 0;
      line = 1'b0;
      repeat (5) step();
      line = 1'b1;
      repeat (48) step();
      check("glitch_vld", v0, 0);

      for (int i = 0; i < 11; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         send(vecs[i].dut, vecs[i].data, vecs[i].pbit, vecs[i].stop_lv, -1, -1, -1);
         wait_valid(nm);
         check({nm, "_data"}, m_data, vecs[i].exp_data);
         check({nm, "_perr"}, m_perr, vecs[i].exp_pe);
         check({nm, "_ferr"}, m_ferr, vecs[i].exp_fe);
         take(nm);
         repeat (3 * clk_of(vecs[i].dut)) step();
      end

      // One-cycle inversion at the centre of data bit 3 of 0x55
      send(0, 9'h055, -1, 2'b11, 4, 8, -1);
      wait_valid("maj");
      check("maj_data", m_data, MAJ_EXP);
      take("maj");
      repeat (48) step();

      // Overrun: second frame arrives while the first is still held
      begin
         int hi0, rise0;
         hi0 = ovr_hi;
         rise0 = ovr_rise;
         send(0, 9'h011, -1, 2'b11, -1, -1, -1);
         send(0, 9'h022, -1, 2'b11, -1, -1, -1);
         repeat (20) step();
         check("ovr_pulses", ovr_rise - rise0, 1);
         check("ovr_width", ovr_hi - hi0, 1);
         check("ovr_data", m_data, 9'h011);
         check("ovr_vld", m_vld, 1);
         take("ovr");
      end
      repeat (48) step();

      // Reset in the middle of a frame while a word is held
      send(0, 9'h011, -1, 2'b11, -1, -1, -1);
      send(0, 9'h000, -1, 2'b11, -1, -1, 60);
      rst = 1'b1;
      step();
      check("midrst_out", {d0, v0, pe0, fe0, ov0}, 0);
      rst = 1'b0;
      repeat (4) step();
      send(0, 9'h096, -1, 2'b11, -1, -1, -1);
      wait_valid("postrst");
      check("postrst_data", m_data, 9'h096);
      check("postrst_err", {m_perr, m_ferr}, 0);
      take("postrst");
      repeat (48) step();

      for (int i = 0; i < 24; i++) begin
         int         d, pb, nb;
         logic [8:0] dat;
         logic [1:0] sl;
         logic       exp_fe;
         string      nm;
         nm  = $sformatf("rnd%0d", i);
         d   = ($urandom_range(0, 1) == 0) ? 0 : 2;
         nb  = nb_of(d);
         dat = 9'($urandom) & 9'((1 << nb) - 1);
         pb  = (pm_of(d) != 0) ? int'($urandom_range(0, 1)) : 0;
         sl  = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
         exp_fe = (sl[0] == 1'b0);
         send(d, dat, (pm_of(d) != 0) ? pb : -1, sl, -1, -1, -1);
         wait_valid(nm);
         check({nm, "_data"}, m_data, dat);
         check({nm, "_perr"}, m_perr, exp_perr(d, dat, pb));
         check({nm, "_ferr"}, m_ferr, exp_fe);
         take(nm);
         repeat (3 * clk_of(d)) step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
